// File: rtl/score_renderer_pkg.sv
// Shared glyph encoding and box geometry for the score digits.
// The GLYPH_n constants are the same ones the score glyph encoder emits.
package score_pkg;
  localparam int GLYPH_W = 13;
  typedef logic [GLYPH_W-1:0] glyph_t;

  localparam glyph_t GLYPH_0 = 13'h1FBF;
  localparam glyph_t GLYPH_1 = 13'h0529;
  localparam glyph_t GLYPH_2 = 13'h1DF7;
  localparam glyph_t GLYPH_3 = 13'h1DEF;
  localparam glyph_t GLYPH_4 = 13'h17E9;
  localparam glyph_t GLYPH_5 = 13'h1EEF;
  localparam glyph_t GLYPH_6 = 13'h1EFF;
  localparam glyph_t GLYPH_7 = 13'h1D29;
  localparam glyph_t GLYPH_8 = 13'h1FFF;
  localparam glyph_t GLYPH_9 = 13'h1FEF;

  // Lowest bit index of each glyph row; rows 1 and 3 have no middle cell.
  localparam int ROW0_OFS = 10;
  localparam int ROW1_OFS = 8;
  localparam int ROW2_OFS = 5;
  localparam int ROW3_OFS = 3;
  localparam int ROW4_OFS = 0;

  localparam int BOX_COLS = 7;
  localparam int BOX_ROWS = 5;

  typedef struct packed {
    logic       inbox;
    logic [2:0] row;
    logic [2:0] col;
  } cell_pos_t;
endpackage

// File: rtl/score_renderer_if.sv
// Pixel-stream and glyph interface between the VGA timing/encoder side and the renderer.
interface score_renderer_if;
  import score_pkg::*;
  logic       frame_start;
  glyph_t     digit1;
  glyph_t     digit2;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       blink_en;
  logic       pixel_on;
  logic       pixel_valid;

  modport master (
    output frame_start, digit1, digit2, pixel_x, pixel_y, video_on, blink_en,
    input  pixel_on, pixel_valid
  );
  modport slave (
    input  frame_start, digit1, digit2, pixel_x, pixel_y, video_on, blink_en,
    output pixel_on, pixel_valid
  );
endinterface

// File: rtl/score_renderer_lookup.sv
// Combinational glyph cell lookup: one bit of a 3x5 glyph selected by (row, col).
// col 3 and rows above 4 read as off, which also covers the inter-digit gap.
module glyph_cell_lookup
  import score_pkg::*;
(
  input  glyph_t     glyph,
  input  logic [2:0] row,
  input  logic [1:0] col,
  output logic       bit_on
);
  always_comb begin
    bit_on = 1'b0;
    case ({row, col})
      5'b000_00: bit_on = glyph[ROW0_OFS+2];
      5'b000_01: bit_on = glyph[ROW0_OFS+1];
      5'b000_10: bit_on = glyph[ROW0_OFS];
      5'b001_00: bit_on = glyph[ROW1_OFS+1];
      5'b001_10: bit_on = glyph[ROW1_OFS];
      5'b010_00: bit_on = glyph[ROW2_OFS+2];
      5'b010_01: bit_on = glyph[ROW2_OFS+1];
      5'b010_10: bit_on = glyph[ROW2_OFS];
      5'b011_00: bit_on = glyph[ROW3_OFS+1];
      5'b011_10: bit_on = glyph[ROW3_OFS];
      5'b100_00: bit_on = glyph[ROW4_OFS+2];
      5'b100_01: bit_on = glyph[ROW4_OFS+1];
      5'b100_10: bit_on = glyph[ROW4_OFS];
      default:   bit_on = 1'b0;
    endcase
  end
endmodule

// File: rtl/score_renderer.sv
// Two-digit score rasteriser: fixed 2-cycle pixel pipeline, per-frame glyph
// shadows (no tearing), optional tens zero blanking and frame-counted blink.
module score_renderer
  import score_pkg::*;
#(
  parameter int X0            = 16,
  parameter int Y0            = 16,
  parameter int SCALE_LOG2    = 3,
  parameter int SUPPRESS_ZERO = 1,
  parameter int BLINK_FRAMES  = 30
) (
  input logic              clk,
  input logic              rst_n,
  score_renderer_if.slave  bus
);
  localparam int STAGES = 2;
  localparam int CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [10:0] BOX_W = 11'(BOX_COLS << SCALE_LOG2);
  localparam logic [10:0] BOX_H = 11'(BOX_ROWS << SCALE_LOG2);

  logic [10:0]      relx, rely;
  cell_pos_t        pos, s1;
  logic [STAGES:1]  vld_pipe;
  logic             pix_r;
  glyph_t           shadow_tens, shadow_ones;
  logic [CNT_W-1:0] cnt;
  logic             visible;
  logic             tens_bit, ones_bit, cell_bit, tens_col, tens_blank;

  // 11-bit subtraction: bit 10 set means the pixel is left of / above the box.
  assign relx = {1'b0, bus.pixel_x} - 11'(X0);
  assign rely = {1'b0, bus.pixel_y} - 11'(Y0);

  always_comb begin
    pos.inbox = !relx[10] && !rely[10] && (relx < BOX_W) && (rely < BOX_H);
    pos.col   = 3'(relx >> SCALE_LOG2);
    pos.row   = 3'(rely >> SCALE_LOG2);
  end

  // Glyph shadows and blink state change only at frame boundaries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_tens <= '0;
      shadow_ones <= '0;
      cnt         <= '0;
      visible     <= 1'b1;
    end else begin
      if (bus.frame_start) begin
        shadow_tens <= bus.digit2;
        shadow_ones <= bus.digit1;
      end
      if (!bus.blink_en) begin
        cnt     <= '0;
        visible <= 1'b1;
      end else if (bus.frame_start) begin
        if (cnt == CNT_LAST) begin
          cnt     <= '0;
          visible <= ~visible;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  glyph_cell_lookup u_tens (
    .glyph  (shadow_tens),
    .row    (s1.row),
    .col    (s1.col[1:0]),
    .bit_on (tens_bit)
  );

  glyph_cell_lookup u_ones (
    .glyph  (shadow_ones),
    .row    (s1.row),
    .col    (s1.col[1:0]),
    .bit_on (ones_bit)
  );

  // Cols 4-6 have col[2] set and map to ones cols 0-2; col 3 hits the lookup's off column.
  assign tens_col   = !s1.col[2];
  assign cell_bit   = s1.col[2] ? ones_bit : tens_bit;
  assign tens_blank = (SUPPRESS_ZERO != 0) && (shadow_tens == GLYPH_0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1       <= '0;
      vld_pipe <= '0;
      pix_r    <= 1'b0;
    end else begin
      s1       <= pos;
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.video_on};
      pix_r    <= s1.inbox & vld_pipe[1] & visible & cell_bit & !(tens_col & tens_blank);
    end
  end

  assign bus.pixel_on    = pix_r;
  assign bus.pixel_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_score_renderer.sv
// Randomised bench for score_renderer against a cell-grid reference model;
// a second instance with zero suppression disabled shares the same stimulus.
module tb_score_renderer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        fs, vo, be;
  logic [12:0] d1, d2;
  logic [9:0]  px, py;
  logic [12:0] n_d1, n_d2;
  logic        n_be;

  score_renderer_if bus0();
  score_renderer_if bus1();

  assign bus0.frame_start = fs;  assign bus1.frame_start = fs;
  assign bus0.digit1 = d1;       assign bus1.digit1 = d1;
  assign bus0.digit2 = d2;       assign bus1.digit2 = d2;
  assign bus0.pixel_x = px;      assign bus1.pixel_x = px;
  assign bus0.pixel_y = py;      assign bus1.pixel_y = py;
  assign bus0.video_on = vo;     assign bus1.video_on = vo;
  assign bus0.blink_en = be;     assign bus1.blink_en = be;

  score_renderer #(.X0(16), .Y0(16), .SCALE_LOG2(3), .SUPPRESS_ZERO(1), .BLINK_FRAMES(2))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus0));
  score_renderer #(.X0(16), .Y0(16), .SCALE_LOG2(3), .SUPPRESS_ZERO(0), .BLINK_FRAMES(2))
    dut_nz (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [12:0] m_tens, m_ones;
  int          m_cnt;
  bit          m_vis;
  typedef struct { bit on0; bit on1; bit vld; } exp_t;
  exp_t q[$];

  // Bit index for each cell of the 3x5 grid, row-major; -1 = always off
  int cell_idx [15] = '{12, 11, 10, 9, -1, 8, 7, 6, 5, 4, -1, 3, 2, 1, 0};
  logic [12:0] glyphs [10] = '{13'h1FBF, 13'h0529, 13'h1DF7, 13'h1DEF, 13'h17E9,
                               13'h1EEF, 13'h1EFF, 13'h1D29, 13'h1FFF, 13'h1FEF};

  function automatic bit model_pix(int x, int y, logic [12:0] tens, logic [12:0] ones, bit supp);
    int rx, ry, col, row, c, idx;
    logic [12:0] g;
    rx = x - 16;
    ry = y - 16;
    if (rx < 0 || ry < 0 || rx >= 7 * 8 || ry >= 5 * 8) return 1'b0;
    col = rx / 8;
    row = ry / 8;
    if (col == 3) return 1'b0;
    if (col < 3) begin
      if (supp && tens == 13'h1FBF) return 1'b0;
      g = tens;
      c = col;
    end else begin
      g = ones;
      c = col - 4;
    end
    idx = cell_idx[row * 3 + c];
    if (idx < 0) return 1'b0;
    return g[idx];
  endfunction

  // One cycle: check output due from two cycles ago, drive this cycle, advance the model.
  task automatic step(bit f, int x, int y, bit v, bit r = 1'b1);
    exp_t e;
    @(negedge clk);
    if (q.size() == 2) begin
      e = q.pop_front();
      chk("pix_on", bus0.pixel_on, e.on0);
      chk("pix_on_nz", bus1.pixel_on, e.on1);
      chk("pix_valid", bus0.pixel_valid, e.vld);
    end
    fs = f; px = 10'(x); py = 10'(y); vo = v; rst_n = r;
    d1 = n_d1; d2 = n_d2; be = n_be;
    if (!r) begin
      m_tens = '0; m_ones = '0; m_cnt = 0; m_vis = 1'b1;
      foreach (q[i]) q[i] = '{1'b0, 1'b0, 1'b0};
      e = '{1'b0, 1'b0, 1'b0};
    end else begin
      if (f) begin
        m_tens = d2;
        m_ones = d1;
      end
      if (!be) begin
        m_cnt = 0;
        m_vis = 1'b1;
      end else if (f) begin
        if (m_cnt == 2 - 1) begin
          m_cnt = 0;
          m_vis = !m_vis;
        end else m_cnt++;
      end
      e.on0 = v && m_vis && model_pix(x, y, m_tens, m_ones, 1'b1);
      e.on1 = v && m_vis && model_pix(x, y, m_tens, m_ones, 1'b0);
      e.vld = v;
    end
    q.push_back(e);
  endtask

  task automatic probe(int x, int y, bit e0, bit e1);
    step(1'b0, x, y, 1'b1);
    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    chk($sformatf("probe_%0d_%0d", x, y), bus0.pixel_on, e0);
    chk($sformatf("probe_nz_%0d_%0d", x, y), bus1.pixel_on, e1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    fs = 0; vo = 0; be = 0; d1 = 0; d2 = 0; px = 0; py = 0;
    n_d1 = 0; n_d2 = 0; n_be = 0;
    m_tens = 0; m_ones = 0; m_cnt = 0; m_vis = 1'b1;

    // Reset, then scan the box with blank shadows
    step(1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    chk("rst_on", bus0.pixel_on, 1'b0);
    chk("rst_valid", bus0.pixel_valid, 1'b0);
    for (int y = 16; y < 56; y += 2)
      for (int x = 16; x < 72; x += 2)
        step(1'b0, x, y, 1'b1);

    // Tens 4, ones 2
    n_d2 = 13'h17E9; n_d1 = 13'h1DF7;
    step(1'b1, 0, 0, 1'b0);
    probe(16, 16, 1, 1);
    probe(24, 16, 0, 0);
    probe(40, 16, 0, 0);
    probe(48, 24, 0, 0);
    probe(64, 24, 1, 1);

    // Both 8, middle cells and box edges
    n_d2 = 13'h1FFF; n_d1 = 13'h1FFF;
    step(1'b1, 0, 0, 1'b0);
    probe(24, 24, 0, 0);
    probe(24, 32, 1, 1);
    probe(15, 16, 0, 0);
    probe(72, 16, 0, 0);
    probe(16, 56, 0, 0);

    // Input change without frame_start is invisible until the next frame
    n_d1 = 13'h0529;
    probe(48, 16, 1, 1);
    step(1'b1, 0, 0, 1'b0);
    probe(48, 16, 0, 0);
    probe(64, 16, 1, 1);

    // Tens zero: blanked only with suppression enabled
    n_d2 = 13'h1FBF; n_d1 = 13'h1DF7;
    step(1'b1, 0, 0, 1'b0);
    probe(16, 16, 0, 1);
    probe(32, 40, 0, 1);
    probe(48, 16, 1, 1);

    // Blink
    n_d2 = 13'h17E9;
    step(1'b1, 0, 0, 1'b0);
    n_be = 1'b1;
    step(1'b0, 0, 0, 1'b0);
    step(1'b1, 0, 0, 1'b0);
    step(1'b1, 0, 0, 1'b0);
    probe(16, 16, 0, 0);
    step(1'b1, 0, 0, 1'b0);
    step(1'b1, 0, 0, 1'b0);
    probe(16, 16, 1, 1);
    step(1'b1, 0, 0, 1'b0);
    step(1'b1, 0, 0, 1'b0);
    probe(16, 16, 0, 0);
    n_be = 1'b0;
    probe(16, 16, 1, 1);

    // Reset mid-line
    step(1'b0, 16, 16, 1'b1);
    step(1'b0, 17, 16, 1'b1);
    step(1'b0, 18, 16, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    chk("rst_mid_on", bus0.pixel_on, 1'b0);
    chk("rst_mid_valid", bus0.pixel_valid, 1'b0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bit f, r;
      if ($urandom_range(0, 9) == 0) n_d1 = 13'($urandom);
      if ($urandom_range(0, 9) == 0) n_d2 = 13'($urandom);
      f = ($urandom_range(0, 39) == 0);
      if (f) begin
        n_d1 = glyphs[$urandom_range(0, 9)];
        n_d2 = ($urandom_range(0, 3) == 0) ? 13'h1FBF : glyphs[$urandom_range(0, 9)];
      end
      if ($urandom_range(0, 149) == 0) n_be = !n_be;
      r = ($urandom_range(0, 599) != 0);
      step(f, int'($urandom_range(0, 90)), int'($urandom_range(0, 70)),
           $urandom_range(0, 7) != 0, r);
    end
    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
